// File: rtl/vregfile_port_arbiter.sv
// Two-read / two-write round-robin arbiter in front of a single-read, single-write register file.
// It forwards same-cycle write data to a colliding read, and exposes its arbitration state on dbg_* outputs.
module vregfile_port_arbiter #(
  parameter int WIDTH       = 32,
  parameter int NUMREGS     = 16,
  parameter int LOG2NUMREGS = 4
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   rd0_req,
  input  logic [LOG2NUMREGS-1:0] rd0_reg,
  output logic                   rd0_gnt,
  output logic                   rd0_valid,
  output logic [WIDTH-1:0]       rd0_data,
  input  logic                   rd1_req,
  input  logic [LOG2NUMREGS-1:0] rd1_reg,
  output logic                   rd1_gnt,
  output logic                   rd1_valid,
  output logic [WIDTH-1:0]       rd1_data,
  input  logic                   wr0_req,
  input  logic [LOG2NUMREGS-1:0] wr0_reg,
  input  logic [WIDTH-1:0]       wr0_data,
  output logic                   wr0_gnt,
  input  logic                   wr1_req,
  input  logic [LOG2NUMREGS-1:0] wr1_reg,
  input  logic [WIDTH-1:0]       wr1_data,
  output logic                   wr1_gnt,
  output logic [LOG2NUMREGS-1:0] a_reg,
  output logic                   a_en,
  input  logic [WIDTH-1:0]       a_readdataout,
  output logic [LOG2NUMREGS-1:0] c_reg,
  output logic [WIDTH-1:0]       c_writedatain,
  output logic                   c_we,
  output logic                   dbg_rd_pri,
  output logic                   dbg_wr_pri,
  output logic                   dbg_byp_sel
);

  if (NUMREGS > (1 << LOG2NUMREGS)) begin : g_param_check
    $error("LOG2NUMREGS too small for NUMREGS");
  end

  // Handshake: a requester holds req/reg/data until it sees its gnt in the same cycle;
  // rdN_valid/rdN_data answer exactly one cycle after rdN_gnt, with no back-pressure.
  logic             rd_pri_q, rd_pri_d;
  logic             wr_pri_q, wr_pri_d;
  logic             rd0_valid_q, rd0_valid_d;
  logic             rd1_valid_q, rd1_valid_d;
  logic             byp_sel_q, byp_sel_d;
  logic [WIDTH-1:0] byp_data_q, byp_data_d;
  logic             byp_hit;
  logic [WIDTH-1:0] rd_word;

  always_comb begin
    // pri = 0 favours requester 0 when both ask
    rd0_gnt = rd0_req & (~rd1_req | ~rd_pri_q);
    rd1_gnt = rd1_req & (~rd0_req |  rd_pri_q);
    wr0_gnt = wr0_req & (~wr1_req | ~wr_pri_q);
    wr1_gnt = wr1_req & (~wr0_req |  wr_pri_q);

    rd_pri_d = rd_pri_q;
    if (rd0_gnt)      rd_pri_d = 1'b1;
    else if (rd1_gnt) rd_pri_d = 1'b0;
    wr_pri_d = wr_pri_q;
    if (wr0_gnt)      wr_pri_d = 1'b1;
    else if (wr1_gnt) wr_pri_d = 1'b0;

    a_en          = rd0_gnt | rd1_gnt;
    a_reg         = rd1_gnt ? rd1_reg : rd0_reg;
    c_we          = wr0_gnt | wr1_gnt;
    c_reg         = wr1_gnt ? wr1_reg : wr0_reg;
    c_writedatain = wr1_gnt ? wr1_data : wr0_data;

    // The register file returns stale data on a same-address read/write, so forward the write.
    byp_hit    = a_en & c_we & (c_reg == a_reg);
    byp_sel_d  = byp_hit;
    byp_data_d = byp_hit ? c_writedatain : byp_data_q;

    rd0_valid_d = rd0_gnt;
    rd1_valid_d = rd1_gnt;

    rd_word  = byp_sel_q ? byp_data_q : a_readdataout;
    rd0_data = rd0_valid_q ? rd_word : '0;
    rd1_data = rd1_valid_q ? rd_word : '0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_pri_q    <= 1'b0;
      wr_pri_q    <= 1'b0;
      rd0_valid_q <= 1'b0;
      rd1_valid_q <= 1'b0;
      byp_sel_q   <= 1'b0;
      byp_data_q  <= '0;
    end else begin
      rd_pri_q    <= rd_pri_d;
      wr_pri_q    <= wr_pri_d;
      rd0_valid_q <= rd0_valid_d;
      rd1_valid_q <= rd1_valid_d;
      byp_sel_q   <= byp_sel_d;
      byp_data_q  <= byp_data_d;
    end
  end

  assign rd0_valid   = rd0_valid_q;
  assign rd1_valid   = rd1_valid_q;
  assign dbg_rd_pri  = rd_pri_q;
  assign dbg_wr_pri  = wr_pri_q;
  assign dbg_byp_sel = byp_sel_q;

endmodule

// File: doc/vregfile_port_arbiter.md
VREGFILE_PORT_ARBITER -- requirements
Module: vregfile_port_arbiter

Interface
REQ-001: Parameter WIDTH, default 32, data width of one register.
REQ-002: Parameter NUMREGS, default 16, number of registers in the attached register file.
REQ-003: Parameter LOG2NUMREGS, default 4, register index width.
REQ-004: The block SHALL use one clock and an asynchronous, active-low reset:
- clk  input  1  clock; all state updates on the rising edge.
- resetn  input  1  asynchronous active-low reset.
REQ-005: Read requester 0 ports:
- rd0_req  input  1  read request.
- rd0_reg  input  LOG2NUMREGS  register to read.
- rd0_gnt  output  1  request granted this cycle.
- rd0_valid  output  1  read data valid.
- rd0_data  output  WIDTH  read data.
REQ-006: Read requester 1 ports are identical to REQ-005 with prefix rd1_.
REQ-007: Write requester 0 ports:
- wr0_req  input  1  write request.
- wr0_reg  input  LOG2NUMREGS  destination register.
- wr0_data  input  WIDTH  write data.
- wr0_gnt  output  1  write performed this cycle.
REQ-008: Write requester 1 ports are identical to REQ-007 with prefix wr1_.
REQ-009: Register-file read port:
- a_reg  output  LOG2NUMREGS  read address.
- a_en  output  1  read enable.
- a_readdataout  input  WIDTH  read data, returned one cycle after the address and enable.
REQ-010: Register-file write port:
- c_reg  output  LOG2NUMREGS  write address.
- c_writedatain  output  WIDTH  write data.
- c_we  output  1  write enable.

Function
REQ-011: Read grant SHALL be combinational in the request cycle. At most one of rd0_gnt/rd1_gnt is high per cycle.
REQ-012: Read arbitration SHALL be round-robin:
- A lone requester is always granted.
- When both request, the requester indicated by rd_pri wins.
- After each read grant, rd_pri SHALL point to the non-granted requester.
- rd_pri SHALL be unchanged in cycles with no read grant.
REQ-013: a_en SHALL equal rd0_gnt|rd1_gnt. a_reg SHALL be the granted requester's reg, and rd0_reg when there is no grant.
REQ-014: Write arbitration SHALL be independent round-robin using pointer wr_pri, with rules identical to REQ-012.
REQ-015: c_we SHALL equal wr0_gnt|wr1_gnt. c_reg and c_writedatain SHALL be taken from the granted write requester, and from wr0 when there is no grant.
REQ-016: Requesters hold req, reg and data stable until granted. The block SHALL NOT queue requests.
REQ-017: rdN_valid SHALL be a registered copy of rdN_gnt, giving exactly 1 cycle latency. Back-to-back grants SHALL produce back-to-back valids.
REQ-018: rdN_data SHALL be driven only while rdN_valid is high, and SHALL be 0 otherwise.
REQ-019: Read-during-write hazard handling:
- The register file returns old data on a same-cycle read/write to the same address.
- When a read is granted, c_we=1 and c_reg==a_reg in the same cycle, the block SHALL capture c_writedatain in a bypass register and set byp_sel.
- In the following cycle, the valid read data SHALL be the bypass register; otherwise it SHALL be a_readdataout.
REQ-020: byp_sel SHALL be cleared in every cycle with no read grant, or with no matching write.
REQ-021: A read and a write may be granted in the same cycle. Two reads never share a cycle, and neither do two writes.
REQ-022: The block SHALL contain no combinational path from a_readdataout to any grant output.

Reset
REQ-023: While resetn=0, all of the following SHALL hold:
- rd0_valid=0 and rd1_valid=0.
- byp_sel=0.
- The bypass register holds 0.
- rd_pri=0 and wr_pri=0, meaning requester 0 is favoured.
REQ-024: Grant outputs are combinational and SHALL still follow REQ-011/014 during reset. Requesters shall not assert req while resetn=0.
REQ-025: A reset asserted between a grant and its valid SHALL discard that read: no valid is produced after reset release.

Verification
REQ-026: Reset release, then rd0_req=1 with rd0_reg=3 (reg3=0xA5) -> rd0_gnt=1 that cycle, a_en=1, a_reg=3; next cycle rd0_valid=1 and rd0_data=0xA5.
REQ-027: rd0_req and rd1_req both held for 4 cycles after reset -> grant order rd0, rd1, rd0, rd1; valids follow one cycle later, with the same order.
REQ-028: wr1 writes reg5=0x1234 in the same cycle that rd0 is granted reg5 (old value 0) -> next cycle rd0_data=0x1234, not 0.
REQ-029: wr0_req and wr1_req held together for 3 cycles -> grant order wr0, wr1, wr0; c_reg and c_writedatain match the granted requester in each cycle.
REQ-030: resetn pulsed low for 1 cycle immediately after rd1_gnt -> rd1_valid stays 0 and rd_pri=0 after release.
REQ-031: A random bench runs 10k cycles against a reference register-file model -> every rdN_data matches the model, including the bypass case, and no cycle shows two read grants or two write grants.
